// File: rtl/pipe_adder_pkg.sv
// rtl/pipe_adder_pkg.sv - shared types and helpers for the pipelined adder
package pipe_adder_pkg;

   // Width of the carry segment handled by each pipeline stage
   function automatic int seg_w(input int width, input int stages);
      return width / stages;
   endfunction

   // Control part of a stage payload; the operand and sum fields are WIDTH
   // dependent and are wrapped around this in the top level
   typedef struct packed {
      logic valid;
      logic carry;
      logic sub;
      logic sat;
   } stage_ctrl_t;

endpackage

// File: rtl/pipe_adder_seg.sv
// rtl/pipe_adder_seg.sv - SEG-bit combinational adder slice used by each pipeline stage
module adder_seg #(
   parameter int SEG = 8
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           cin,
   output logic [SEG-1:0] s,
   output logic           cout,
   output logic           c_msb_in
);

   logic [SEG:0] full;

   assign full     = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
   assign s        = full[SEG-1:0];
   assign cout     = full[SEG];
   // The sum bit is a^b^carry_in, so the carry into the top bit is recoverable
   assign c_msb_in = a[SEG-1] ^ b[SEG-1] ^ s[SEG-1];

endmodule

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - pipelined add/subtract with valid/ready; PIPE_ADDER_SAT_EN adds sat_i clamping
module pipe_adder
   import pipe_adder_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   input  logic             sub_i,
   input  logic             cin_i,
`ifdef PIPE_ADDER_SAT_EN
   input  logic             sat_i,
`endif
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o,
   output logic             ovf_o,
   output logic             zero_o
);

   localparam int SEG = seg_w(WIDTH, STAGES);
   localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   // One slot of the pipeline: operand bits still to be added, sum bits
   // already produced, and the carry chained into the next segment
   typedef struct packed {
      stage_ctrl_t      ctrl;
      logic [WIDTH-1:0] a_rem;
      logic [WIDTH-1:0] b_rem;
      logic [WIDTH-1:0] sum_done;
   } stage_t;

   stage_t     in_stage;
   stage_t     nxt_w  [STAGES];
   stage_t     pipe_q [STAGES];
   stage_t     fin;
   logic       fin_ovf;
   logic       fin_zero;
   logic       ovf_q;
   logic       zero_q;
   logic       sat_in;
   logic       en;

`ifdef PIPE_ADDER_SAT_EN
   assign sat_in = sat_i;
`else
   assign sat_in = 1'b0;
`endif

   // Whole pipeline moves together; a full output that is not taken freezes it
   assign en      = !valid_o || ready_i;
   assign ready_o = en;

   // Subtract is A + ~B + 1, so the inversion and forced carry happen on entry
   always_comb begin
      in_stage              = '0;
      in_stage.ctrl.valid   = valid_i;
      in_stage.ctrl.carry   = sub_i | cin_i;
      in_stage.ctrl.sub     = sub_i;
      in_stage.ctrl.sat     = sat_in;
      in_stage.a_rem        = src1_i;
      in_stage.b_rem        = sub_i ? ~src2_i : src2_i;
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      stage_t         cur;
      stage_t         nxt;
      logic [SEG-1:0] seg_s;
      logic           seg_cout;
      logic           seg_cmsb;

      if (k == 0) begin : g_head
         assign cur = in_stage;
      end else begin : g_body
         assign cur = pipe_q[k-1];
      end

      adder_seg #(
         .SEG (SEG)
      ) u_seg (
         .a        (cur.a_rem[k*SEG +: SEG]),
         .b        (cur.b_rem[k*SEG +: SEG]),
         .cin      (cur.ctrl.carry),
         .s        (seg_s),
         .cout     (seg_cout),
         .c_msb_in (seg_cmsb)
      );

      // Fold this segment's sum in, pass the carry on, retire the used operand bits
      always_comb begin
         nxt                        = cur;
         nxt.ctrl.carry             = seg_cout;
         nxt.sum_done[k*SEG +: SEG] = seg_s;
         nxt.a_rem[k*SEG +: SEG]    = '0;
         nxt.b_rem[k*SEG +: SEG]    = '0;
      end

      assign nxt_w[k] = nxt;

      if (k == STAGES-1) begin : g_last
         assign fin_ovf = seg_cmsb ^ seg_cout;
      end
   end

   // Last stage: clamp on overflow when requested, then derive the zero flag
   always_comb begin
      fin = nxt_w[STAGES-1];
      if (fin.ctrl.sat && fin_ovf) begin
         fin.sum_done = fin.sum_done[WIDTH-1] ? MAX_POS : MAX_NEG;
      end
      fin_zero = (fin.sum_done == '0);
   end

   // Pipeline registers; reset empties every slot so nothing in flight survives
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int k = 0; k < STAGES; k++) begin
            pipe_q[k] <= '0;
         end
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else if (en) begin
         for (int k = 0; k < STAGES-1; k++) begin
            pipe_q[k] <= nxt_w[k];
         end
         pipe_q[STAGES-1] <= fin;
         ovf_q            <= fin_ovf;
         zero_q           <= fin_zero;
      end
   end

   assign valid_o = pipe_q[STAGES-1].ctrl.valid;
   assign sum_o   = pipe_q[STAGES-1].sum_done;
   assign cout_o  = pipe_q[STAGES-1].ctrl.carry;
   assign ovf_o   = ovf_q;
   assign zero_o  = zero_q;

endmodule
